// File: rtl/uart_test_harness.sv
// UART loopback harness: collects 8N1 bytes until 0x00, then replays them plus 0x00.
// Optional macro UART_TEST_HARNESS_UPPERCASE_EN folds lowercase ASCII to uppercase on buffer write.
module uart_test_harness #(
  parameter int BAUD_RATE       = 115200,
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int MAX_LENGTH      = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic uart_receive,
  output logic uart_transmit
);

  localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int CNT_W  = $clog2(MAX_LENGTH + 1);
  localparam int IDX_W  = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
  localparam logic [CW-1:0]    CPB_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LENGTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {CTL_COLLECT, CTL_SEND, CTL_TERM} ctl_state_t;

  function automatic logic [7:0] fold_case(input logic [7:0] b);
`ifdef UART_TEST_HARNESS_UPPERCASE_EN
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    else return b;
`else
    return b;
`endif
  endfunction

  logic             sync1_r, sync2_r;
  rx_state_t        rx_state_r, rx_next_s;
  logic [CW-1:0]    rx_cnt_r;
  logic [2:0]       rx_bit_r;
  logic [7:0]       rx_shift_r;
  logic             rx_valid_r;
  logic             rx_tick_s;

  ctl_state_t       ctl_state_r, ctl_next_s;
  logic [CNT_W-1:0] count_r, rd_idx_r;
  logic             overflow_r, term_sent_r;
  logic [7:0]       buf_r [MAX_LENGTH];
  logic             wr_en_s, tx_load_s;
  logic [7:0]       tx_byte_s;

  logic [9:0]       tx_shift_r;
  logic [CW-1:0]    tx_cnt_r;
  logic [3:0]       tx_bit_r;
  logic             tx_active_r;
  logic             tx_done_s, tx_ready_s;

  assign rx_tick_s  = (rx_cnt_r == CPB_M1);
  assign tx_done_s  = tx_active_r && (tx_bit_r == 4'd9) && (tx_cnt_r == CPB_M1);
  assign tx_ready_s = !tx_active_r || tx_done_s;
  assign uart_transmit = tx_shift_r[0];

  // RX state register
  always_ff @(posedge clock) begin
    if (!reset) rx_state_r <= RX_IDLE;
    else        rx_state_r <= rx_next_s;
  end

  // RX next-state logic; START re-checks the line at mid start bit to reject glitches
  always_comb begin
    rx_next_s = rx_state_r;
    case (rx_state_r)
      RX_IDLE:  if (!sync2_r) rx_next_s = RX_START; else rx_next_s = RX_IDLE;
      RX_START: if (rx_cnt_r == HALF_M1) rx_next_s = sync2_r ? RX_IDLE : RX_DATA;
                else rx_next_s = RX_START;
      RX_DATA:  if (rx_tick_s && rx_bit_r == 3'd7) rx_next_s = RX_STOP; else rx_next_s = RX_DATA;
      RX_STOP:  if (rx_tick_s) rx_next_s = RX_IDLE; else rx_next_s = RX_STOP;
      default:  rx_next_s = RX_IDLE;
    endcase
  end

  // RX synchronizer, bit timing and byte assembly
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_r    <= 1'b1;
      sync2_r    <= 1'b1;
      rx_cnt_r   <= '0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
      rx_valid_r <= 1'b0;
    end else begin
      sync1_r    <= uart_receive;
      sync2_r    <= sync1_r;
      rx_valid_r <= (rx_state_r == RX_STOP) && rx_tick_s && sync2_r;
      if (rx_state_r == RX_IDLE || rx_state_r != rx_next_s || rx_tick_s) rx_cnt_r <= '0;
      else rx_cnt_r <= rx_cnt_r + CW'(1);
      if (rx_state_r == RX_IDLE) rx_bit_r <= 3'd0;
      else if (rx_state_r == RX_DATA && rx_tick_s) rx_bit_r <= rx_bit_r + 3'd1;
      if (rx_state_r == RX_DATA && rx_tick_s) rx_shift_r <= {sync2_r, rx_shift_r[7:1]};
    end
  end

  // Control state register
  always_ff @(posedge clock) begin
    if (!reset) ctl_state_r <= CTL_COLLECT;
    else        ctl_state_r <= ctl_next_s;
  end

  // Control next-state logic; TERM is held until the 0x00 frame has fully left the line
  always_comb begin
    ctl_next_s = ctl_state_r;
    case (ctl_state_r)
      CTL_COLLECT: if (rx_valid_r && rx_shift_r == 8'h00)
                     ctl_next_s = (count_r == CNT_W'(0)) ? CTL_TERM : CTL_SEND;
                   else ctl_next_s = CTL_COLLECT;
      CTL_SEND:    if (tx_load_s && rd_idx_r == count_r - CNT_W'(1)) ctl_next_s = CTL_TERM;
                   else ctl_next_s = CTL_SEND;
      CTL_TERM:    if (term_sent_r && tx_done_s) ctl_next_s = CTL_COLLECT;
                   else ctl_next_s = CTL_TERM;
      default:     ctl_next_s = CTL_COLLECT;
    endcase
  end

  // Control outputs: buffer write enable and transmitter load requests
  always_comb begin
    wr_en_s   = 1'b0;
    tx_load_s = 1'b0;
    tx_byte_s = 8'h00;
    case (ctl_state_r)
      CTL_COLLECT: wr_en_s = rx_valid_r && (rx_shift_r != 8'h00) && (count_r != MAX_CNT);
      CTL_SEND: begin
        tx_load_s = tx_ready_s;
        tx_byte_s = buf_r[rd_idx_r[IDX_W-1:0]];
      end
      CTL_TERM:    tx_load_s = tx_ready_s && !term_sent_r;
      default:     tx_load_s = 1'b0;
    endcase
  end

  // Control datapath: fill count, overflow flag, replay index
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_r     <= '0;
      overflow_r  <= 1'b0;
      rd_idx_r    <= '0;
      term_sent_r <= 1'b0;
    end else begin
      if (ctl_state_r == CTL_TERM && ctl_next_s == CTL_COLLECT) begin
        count_r    <= '0;
        overflow_r <= 1'b0;
      end else begin
        if (wr_en_s) count_r <= count_r + CNT_W'(1);
        if (ctl_state_r == CTL_COLLECT && rx_valid_r && rx_shift_r != 8'h00 && count_r == MAX_CNT)
          overflow_r <= 1'b1;
      end
      if (ctl_state_r == CTL_COLLECT) rd_idx_r <= '0;
      else if (ctl_state_r == CTL_SEND && tx_load_s) rd_idx_r <= rd_idx_r + CNT_W'(1);
      if (ctl_state_r != CTL_TERM) term_sent_r <= 1'b0;
      else if (tx_load_s) term_sent_r <= 1'b1;
    end
  end

  // String buffer storage
  always_ff @(posedge clock) begin
    if (wr_en_s) buf_r[count_r[IDX_W-1:0]] <= fold_case(rx_shift_r);
  end

  // TX shifter: the frame register bit 0 drives the pin; a load at stop end chains frames gaplessly
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_shift_r  <= 10'h3FF;
      tx_cnt_r    <= '0;
      tx_bit_r    <= 4'd0;
      tx_active_r <= 1'b0;
    end else if (tx_load_s) begin
      tx_shift_r  <= {1'b1, tx_byte_s, 1'b0};
      tx_cnt_r    <= '0;
      tx_bit_r    <= 4'd0;
      tx_active_r <= 1'b1;
    end else if (tx_active_r && tx_cnt_r == CPB_M1) begin
      tx_shift_r  <= {1'b1, tx_shift_r[9:1]};
      tx_cnt_r    <= '0;
      tx_bit_r    <= tx_bit_r + 4'd1;
      tx_active_r <= (tx_bit_r != 4'd9);
    end else if (tx_active_r) begin
      tx_cnt_r    <= tx_cnt_r + CW'(1);
    end else begin
      tx_shift_r  <= 10'h3FF;
    end
  end

endmodule

// File: tb/tb_uart_test_harness.sv
// Scoreboard bench for uart_test_harness: a reference model queues expected reply bytes and a
// line monitor decodes uart_transmit frames and compares them in order.
module tb_uart_test_harness;

  localparam int CPB = 10;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic uart_receive = 1'b1;
  logic uart_transmit;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_q[$];
  logic ignore_mon = 1'b0;

  uart_test_harness #(.BAUD_RATE(10), .CLOCK_FREQUENCY(100), .MAX_LENGTH(16)) dut (
    .clock(clock), .reset(reset), .uart_receive(uart_receive), .uart_transmit(uart_transmit)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] model_fold(input logic [7:0] b);
`ifdef UART_TEST_HARNESS_UPPERCASE_EN
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
    return b;
  endfunction

  // Reference model update happens as the byte is driven; stop_bit=0 makes a framing error.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) begin
      if (b == 8'h00) begin
        foreach (model_q[i]) exp_q.push_back(model_q[i]);
        exp_q.push_back(8'h00);
        model_q.delete();
      end else if (model_q.size() < 16) begin
        model_q.push_back(model_fold(b));
      end
    end
    uart_receive = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_receive = b[i];
      repeat (CPB) @(negedge clock);
    end
    uart_receive = stop_bit;
    repeat (CPB) @(negedge clock);
    uart_receive = 1'b1;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      @(negedge clock);
      t++;
    end
    check(tag, exp_q.size(), 0);
    exp_q.delete();
    repeat (20) @(negedge clock);
  endtask

  // Line monitor: decode each frame at mid-bit, check gapless chaining inside a reply burst
  initial begin
    int gap = 0;
    logic burst = 1'b0;
    logic sb, pb;
    logic [7:0] d, e;
    forever begin
      @(negedge clock);
      gap++;
      if (reset && uart_transmit === 1'b0) begin
        if (burst && !ignore_mon) check("frame_gap", gap, 5);
        repeat (5) @(negedge clock);
        sb = uart_transmit;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          d[i] = uart_transmit;
        end
        repeat (CPB) @(negedge clock);
        pb = uart_transmit;
        gap = 0;
        if (!ignore_mon) begin
          check("start_bit", {31'd0, sb}, 32'd0);
          check("stop_bit", {31'd0, pb}, 32'd1);
          if (exp_q.size() == 0) begin
            check("spurious_frame", {24'd0, d}, 32'h100);
            burst = 1'b0;
          end else begin
            e = exp_q.pop_front();
            check("reply_byte", {24'd0, d}, {24'd0, e});
            burst = (exp_q.size() != 0);
          end
        end else begin
          burst = 1'b0;
        end
      end
    end
  end

  initial begin
    int lows;
    int t;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("reset_line", {31'd0, uart_transmit}, 32'd1);
    check("reset_count", 32'(dut.count_r), 32'd0);
    check("reset_overflow", {31'd0, dut.overflow_r}, 32'd0);

    lows = 0;
    repeat (1000) begin
      @(negedge clock);
      if (uart_transmit !== 1'b1) lows++;
    end
    check("idle_high", lows, 0);

    foreach (model_q[i]) model_q.delete(i);
    send_byte(8'h48, 1'b1); send_byte(8'h65, 1'b1);
    send_byte(8'h6C, 1'b1); send_byte(8'h6C, 1'b1);
    send_byte(8'h00, 1'b1);
    drain("hell_drain");

    send_byte(8'h00, 1'b1);
    check("empty_count", 32'(dut.count_r), 32'd0);
    drain("empty_drain");
    check("empty_count_after", 32'(dut.count_r), 32'd0);

    for (int b = 8'h41; b <= 8'h54; b++) send_byte(8'(b), 1'b1);
    check("ovf_set", {31'd0, dut.overflow_r}, 32'd1);
    check("ovf_count", 32'(dut.count_r), 32'd16);
    send_byte(8'h00, 1'b1);
    drain("ovf_drain");
    check("ovf_cleared", {31'd0, dut.overflow_r}, 32'd0);
    check("ovf_count_cleared", 32'(dut.count_r), 32'd0);

    send_byte(8'h55, 1'b0);
    send_byte(8'h33, 1'b1);
    send_byte(8'h00, 1'b1);
    drain("frame_err_drain");

    send_byte(8'h48, 1'b1); send_byte(8'h65, 1'b1); send_byte(8'h00, 1'b1);
    t = 0;
    while (exp_q.size() > 2 && t < 2000) begin @(negedge clock); t++; end
    check("first_reply_seen", exp_q.size(), 2);
    ignore_mon = 1'b1;
    t = 0;
    while (uart_transmit !== 1'b0 && t < 50) begin @(negedge clock); t++; end
    repeat (3) @(negedge clock);
    check("pre_reset_low", {31'd0, uart_transmit}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("reset_abort_high", {31'd0, uart_transmit}, 32'd1);
    repeat (2) @(negedge clock);
    check("reset_abort_count", 32'(dut.count_r), 32'd0);
    reset = 1'b1;
    exp_q.delete();
    model_q.delete();
    repeat (200) @(negedge clock);
    ignore_mon = 1'b0;
    send_byte(8'h41, 1'b1);
    send_byte(8'h00, 1'b1);
    drain("post_reset_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
